// File: rtl/comb_sweep_tester.sv
// comb_sweep_tester: walks every input vector of a combinational netlist,
// holds each one for SETTLE cycles, then folds the sampled response into
// a MISR. At the end of the sweep the signature is compared to golden.
module comb_sweep_tester #(
    parameter int unsigned           IN_W   = 10,
    parameter int unsigned           OUT_W  = 5,
    parameter int unsigned           SIG_W  = 16,
    parameter int unsigned           SETTLE = 2,
    parameter logic [SIG_W-1:0]      POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]      SEED   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SIG_W-1:0]  golden,
    input  logic [OUT_W-1:0]  resp_in,
    output logic [IN_W-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [IN_W:0]     vec_count
);

    // Counter must be able to hold SETTLE because it increments on every
    // WAIT cycle, including the one that hands over to CAPTURE.
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IN_W:0]     count_q, count_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SIG_W-1:0]  misr_nxt;

    // MISR step: shift left, fold the MSB back through POLY, XOR the response.
    always_comb begin
        misr_nxt = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(resp_in);
    end

    // Next-state and registered-output decode; abort beats the CAPTURE update.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    vec_d   = '0;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    count_d = '0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_WAIT, ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    count_d = '0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (state_q == ST_WAIT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SETTLE - 1))
                        state_d = ST_CAPTURE;
                end else begin
                    sig_d   = misr_nxt;
                    count_d = count_q + (IN_W+1)'(1);
                    if (&vec_q) begin
                        state_d = ST_DONE;
                        pass_d  = (misr_nxt == golden);
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        vec_d   = vec_q + IN_W'(1);
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, async reset to the idle/seed values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            sig_q   <= SEED;
            cnt_q   <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec_out   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign vec_count = count_q;

endmodule

// File: tb/tb_comb_sweep_tester.sv
// Bench for comb_sweep_tester: three parameterizations sharing clock/reset.
module tb_comb_sweep_tester;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance (10-in / 5-out benchmark) ----------
    logic        start0, abort0;
    logic [15:0] golden0;
    logic [4:0]  resp0;
    logic [9:0]  vec0;
    logic        busy0, done0, pass0;
    logic [15:0] sig0;
    logic [10:0] vc0;

    // Behavioural reference of the benchmark netlist; bit 9 = a, bit 4 = y1.
    function automatic logic [4:0] bench_net(input logic [9:0] v);
        logic a, b, c, d, e, f, g, h, i, j;
        {a, b, c, d, e, f, g, h, i, j} = v;
        return {(a & b) | (c ^ d),
                e ^ f ^ g,
                ~(h | i) & j,
                a ^ j ^ (c & e),
                (|v[3:0]) & ~b};
    endfunction

    assign resp0 = bench_net(vec0);

    comb_sweep_tester u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .golden(golden0),
        .resp_in(resp0), .vec_out(vec0), .busy(busy0), .done(done0),
        .pass(pass0), .signature(sig0), .vec_count(vc0)
    );

    // ---------------- minimal instance ------------------------------------
    logic        start1, abort1, resp1;
    logic [15:0] golden1;
    logic        vec1;
    logic        busy1, done1, pass1;
    logic [15:0] sig1;
    logic [1:0]  vc1;

    comb_sweep_tester #(.IN_W(1), .OUT_W(1), .SETTLE(1), .SEED(16'h0000)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .golden(golden1),
        .resp_in(resp1), .vec_out(vec1), .busy(busy1), .done(done1),
        .pass(pass1), .signature(sig1), .vec_count(vc1)
    );

    // ---------------- feedback / control instance -------------------------
    logic        start3, abort3, resp3;
    logic [15:0] golden3;
    logic [3:0]  vec3;
    logic        busy3, done3, pass3;
    logic [15:0] sig3;
    logic [4:0]  vc3;

    comb_sweep_tester #(.IN_W(4), .OUT_W(1), .SETTLE(1), .SEED(16'h8000)) u3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .golden(golden3),
        .resp_in(resp3), .vec_out(vec3), .busy(busy3), .done(done3),
        .pass(pass3), .signature(sig3), .vec_count(vc3)
    );

    function automatic logic [15:0] mstep(input logic [15:0] s, input logic [15:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic [15:0] gold;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [15:0] m;
        tbl[0] = '{r: 1'b1, gold: 16'h0003, exp_sig: 16'h0003, exp_pass: 1'b1};
        tbl[1] = '{r: 1'b1, gold: 16'h0004, exp_sig: 16'h0003, exp_pass: 1'b0};
        tbl[2] = '{r: 1'b0, gold: 16'h0000, exp_sig: 16'h0000, exp_pass: 1'b1};
        tbl[3] = '{r: 1'b0, gold: 16'h0003, exp_sig: 16'h0000, exp_pass: 1'b0};

        rst = 1'b1;
        start0 = 0; abort0 = 0; golden0 = '0;
        start1 = 0; abort1 = 0; golden1 = '0; resp1 = 0;
        start3 = 0; abort3 = 0; golden3 = '0; resp3 = 0;
        #23;
        // reset state
        chk("rst_sig0", sig0, 16'h0000);
        chk("rst_sig3", sig3, 16'h8000);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_vc0", vc0, 0);
        chk("rst_vec0", vec0, 0);
        rst = 1'b0;
        tick();

        // ---- reset mid-sweep ----
        start3 = 1; tick(); start3 = 0;
        repeat (7) tick();
        chk("mid_busy3", busy3, 1);
        chk("mid_vec3", vec3, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy3", busy3, 0);
        chk("arst_vec3", vec3, 0);
        chk("arst_vc3", vc3, 0);
        chk("arst_sig3", sig3, 16'h8000);
        chk("arst_done3", done3, 0);
        #2 rst = 1'b0;
        tick();

        // ---- feedback path, full 16-vector sweep ----
        m = 16'h8000;
        for (int k = 0; k < 16; k++) m = mstep(m, 16'h0000);
        golden3 = m;
        start3 = 1; tick(); start3 = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 1) chk("fb_sig_pre", sig3, 16'h8000);
            if (k == 2) chk("fb_sig_first", sig3, 16'h1021);
            if (k == 31) chk("fb_done_early", done3, 0);
        end
        chk("fb_done", done3, 1);
        chk("fb_busy", busy3, 0);
        chk("fb_sig", sig3, m);
        chk("fb_vc", vc3, 16);
        chk("fb_pass", pass3, 1);
        chk("fb_vec_hold", vec3, 4'hF);
        abort3 = 1; tick(); abort3 = 0;
        chk("abort_in_done", done3, 1);
        chk("abort_in_done_sig", sig3, m);

        // ---- minimal sweep, table driven ----
        for (int i = 0; i < 4; i++) begin
            resp1 = tbl[i].r;
            golden1 = tbl[i].gold;
            start1 = 1; tick(); start1 = 0;
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (k == 1) chk("min_vec_k1", vec1, 0);
                if (k == 3) chk("min_vec_k3", vec1, 1);
                if (k == 3) chk("min_done_k3", done1, 0);
            end
            chk("min_done", done1, 1);
            chk("min_sig", sig1, tbl[i].exp_sig);
            chk("min_pass", pass1, tbl[i].exp_pass);
            chk("min_vc", vc1, 2);
        end

        // ---- control corner cases ----
        start3 = 1; tick();            // accepted from DONE
        tick();                        // start still high in WAIT: ignored
        start3 = 0;
        chk("wstart_busy", busy3, 1);
        chk("wstart_vec", vec3, 0);
        tick();
        chk("wstart_norestart_vec", vec3, 1);
        chk("wstart_norestart_vc", vc3, 1);
        tick();                        // now in CAPTURE for vector 1
        abort3 = 1; tick(); abort3 = 0;
        chk("cap_abort_busy", busy3, 0);
        chk("cap_abort_sig", sig3, 16'h8000);
        chk("cap_abort_vc", vc3, 0);
        chk("cap_abort_vec", vec3, 0);
        chk("cap_abort_done", done3, 0);
        tick();
        chk("cap_abort_idle", busy3, 0);

        start3 = 1; abort3 = 1; tick(); start3 = 0; abort3 = 0;
        chk("idle_start_wins", busy3, 1);
        abort3 = 1; tick(); abort3 = 0;
        chk("wait_abort", busy3, 0);

        start3 = 1; tick();
        for (int k = 1; k <= 32; k++) tick();
        chk("held_done", done3, 1);
        tick();
        chk("held_restart_busy", busy3, 1);
        chk("held_restart_done", done3, 0);
        chk("held_restart_vc", vc3, 0);
        chk("held_restart_sig", sig3, 16'h8000);
        start3 = 0;
        abort3 = 1; tick(); abort3 = 0;

        // ---- default params against the benchmark model ----
        m = 16'h0000;
        for (int v = 0; v < 1024; v++) m = mstep(m, {11'd0, bench_net(v[9:0])});
        golden0 = m;
        start0 = 1; tick(); start0 = 0;
        for (int k = 1; k <= 3072; k++) begin
            tick();
            if (k == 3071) chk("def_done_early", done0, 0);
        end
        chk("def_done", done0, 1);
        chk("def_vc", vc0, 1024);
        chk("def_sig", sig0, m);
        chk("def_pass", pass0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comb_sweep_tester.md
Name: comb_sweep_tester

Overview:
Sequential driver and checker for the flat combinational benchmark netlists in this flow, such as the 10-input / 5-output cases. It drives every input vector onto the netlist inputs, waits a settle interval, and compacts each output response into a MISR signature. At the end of a sweep it compares the signature against a golden value. It sits in the test harness around a synthesized case and gives a pre/post-synthesis equivalence check that needs only one compared word.

Parameters:
IN_W, 10, number of DUT inputs driven (vec_out width); sweep covers 2^IN_W vectors
OUT_W, 5, number of DUT outputs sampled (resp_in width); OUT_W <= SIG_W
SIG_W, 16, MISR/signature width
SETTLE, 2, cycles vec_out is held before resp_in is sampled; legal range >= 1
POLY, 16'h1021, MISR feedback polynomial, SIG_W bits
SEED, 0, MISR value at reset and at sweep start

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  sweep request, sampled in IDLE or DONE only
abort  input  1  cancel the running sweep, return to IDLE
golden  input  SIG_W  expected signature, sampled in the DONE-entry cycle
resp_in  input  OUT_W  DUT outputs; bit OUT_W-1 = first output (y1)
vec_out  output  IN_W  DUT inputs; bit IN_W-1 = first input (a)
busy  output  1  high in WAIT and CAPTURE
done  output  1  high in DONE
pass  output  1  valid when done=1; signature == golden
signature  output  SIG_W  current MISR value
vec_count  output  IN_W+1  number of vectors captured in the current or last sweep

Behaviour:
- Reset (async, immediate): state=IDLE, vec_out=0, busy=0, done=0, pass=0, signature=SEED, vec_count=0, settle counter=0.
- States: IDLE, WAIT, CAPTURE, DONE.
- IDLE/DONE with start=1: at the next edge vec_out=0, signature=SEED, vec_count=0, settle counter=0, pass=0, done=0, go to WAIT.
- WAIT: the settle counter increments each cycle. After exactly SETTLE cycles in WAIT, go to CAPTURE.
- CAPTURE (one cycle): update the MISR and increment vec_count.
  - If vec_out is all-ones: go to DONE and latch pass=(MISR next-value == golden).
  - Otherwise: vec_out+1 (plain binary increment), clear the settle counter, go to WAIT.
- MISR next-value: next = (signature<<1, LSB=0) XOR (signature[SIG_W-1] ? POLY : 0) XOR zero-extend(resp_in).
- DONE: done=1, busy=0. signature, pass and vec_count are held until the next start or rst. vec_out holds the last vector.
- Timing: each vector occupies exactly SETTLE+1 cycles. A full sweep is 2^IN_W*(SETTLE+1) cycles from the start-accept edge to the DONE-entry edge.
- start while busy: ignored.
- abort while busy: state=IDLE at the next edge, vec_out=0, signature=SEED, vec_count=0, done=0, pass=0. abort has priority over the CAPTURE update in the same cycle. abort is ignored in IDLE and DONE.
- start and abort asserted in the same IDLE cycle: start wins, because abort is ignored there.
- vec_count is IN_W+1 bits so that 2^IN_W is representable at the end of a sweep.
- resp_in is treated as combinationally settled after SETTLE cycles. No synchronizer is used; the DUT is on the same clock domain.
- Outputs are registered. busy/done/pass never glitch.

Test Plan:
1. Reset mid-sweep: start, run 7 cycles, pulse rst -> all outputs at reset values immediately (before the next edge), state IDLE; a subsequent start runs a full sweep normally.
2. Minimal sweep, IN_W=1, SETTLE=1, SEED=0, resp_in held 1'b1 (OUT_W=1) -> vec_out 0 for 2 cycles, then 1 for 2 cycles; done asserted on the 4th edge after start-accept; signature=16'h0003; vec_count=2; golden=16'h0003 gives pass=1, golden=16'h0004 gives pass=0.
3. Feedback path, IN_W=4, SETTLE=1, SEED=16'h8000, resp_in=0 -> after the first CAPTURE signature=16'h1021; after 16 vectors signature equals 16 iterations of the shift/XOR rule (bench model); vec_count=16; done 32 cycles after start.
4. Default params against the synthesized 10-in/5-out benchmark and its behavioural model -> identical signatures; pass=1 with golden from the model; sweep length 3072 cycles; vec_count=1024.
5. Control corner cases: start pulsed during WAIT -> no restart; abort in a CAPTURE cycle -> IDLE, signature=SEED, vec_count=0; start held high through DONE -> a new sweep begins on the edge after DONE entry.
